fetch_unit: RTL and testbench

//  LC3 instruction fetch stage: owns the PC and issues instruction-memory reads.

---
 rtl/fetch_unit.sv | 165 ++++++++++++++++
 tb/tb_fetch_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage for an LC3 core. Owns the program counter, issues
//   single-outstanding reads to instruction memory, and buffers the returned
//   words together with their next-PC in a small first-word-fall-through
//   queue. The decode stage consumes the queue head.
//
//   Ports
//     clk, rst_n      clock (posedge) and asynchronous active-low reset
//     enable_fetch    1 = new reads may be issued; 0 only blocks new issue
//     br_taken/taddr  redirect pulse and target from execute/writeback
//     imem_req/addr   read request to instruction memory (held until ack)
//     imem_ack/rdata  read completion; ack may coincide with the first req cycle
//     instr_valid     queue head is valid
//     enable_decode   decode accepts the head this cycle
//     Instr_dout      head instruction (NOP 16'h5020 when empty)
//     npc_out         head PC+1 (16'h0000 when empty)
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [15:0] RESET_PC   = 16'h3000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable_fetch,
  input  logic        br_taken,
  input  logic [15:0] taddr,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        instr_valid,
  input  logic        enable_decode,
  output logic [15:0] Instr_dout,
  output logic [15:0] npc_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [15:0]      NOP     = 16'h5020;

  typedef enum logic [1:0] {
    S_IDLE, // no read outstanding
    S_REQ,  // read outstanding, its data will be queued
    S_DROP  // read outstanding, its data was squashed by a redirect
  } state_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] npc;
  } entry_t;

  state_t           state_q,  state_d;
  logic [15:0]      pc_q,     pc_d;
  logic [15:0]      addr_q,   addr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

  entry_t           mem_q [FIFO_DEPTH];
  entry_t           head;

  logic             push;
  logic             pop;
  logic [15:0]      pc_inc;
  logic [CNT_W-1:0] count_after;

  assign pc_inc = pc_q + 16'd1; // 16-bit wrap: FFFF -> 0000

  // Only REQ-state data is kept; a redirect squashes both the returning word
  // and any same-cycle pop since the whole queue is being discarded.
  assign push        = (state_q == S_REQ) && imem_ack && !br_taken;
  assign pop         = enable_decode && (count_q != '0) && !br_taken;
  assign count_after = count_q + CNT_W'(push) - CNT_W'(pop);

  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    count_d  = count_after;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;

    if (br_taken) begin
      // Redirect wins over everything. An outstanding read cannot be
      // cancelled on the bus, so it is tracked in DROP until its ack.
      pc_d     = taddr;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      unique case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_REQ,
        S_DROP:  state_d = imem_ack ? S_IDLE : S_DROP;
        default: state_d = S_IDLE;
      endcase
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (enable_fetch && (count_q < DEPTH_C)) begin
            state_d = S_REQ;
            addr_d  = pc_q;
          end
        end
        S_REQ: begin
          if (imem_ack) begin
            pc_d = pc_inc;
            // Back-to-back issue only if the queue still has room after this
            // cycle's push and pop, so a push never lands on a full queue.
            if (enable_fetch && (count_after < DEPTH_C)) begin
              state_d = S_REQ;
              addr_d  = pc_inc;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_DROP: begin
          if (imem_ack) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // NOTE: queue storage has no reset; an entry is only observed while count_q
  // says it is valid, and the output mux substitutes NOP/0 otherwise.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{instr: imem_rdata, npc: pc_inc};
  end

  assign head        = mem_q[rd_ptr_q];
  assign instr_valid = (count_q != '0);
  assign Instr_dout  = instr_valid ? head.instr : NOP;
  assign npc_out     = instr_valid ? head.npc   : 16'h0000;

  // Address comes from its own register so it stays frozen in DROP while
  // pc_q already follows the redirect target.
  assign imem_req  = (state_q != S_IDLE);
  assign imem_addr = addr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit. A small memory responder returns ~addr as
//   the instruction word after a programmable number of wait cycles (0 = ack
//   in the first request cycle). Decode pops and memory handshakes are logged
//   into queues and compared with hand-computed values.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        enable_fetch;
  logic        br_taken;
  logic [15:0] taddr;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic        enable_decode;
  logic [15:0] Instr_dout;
  logic [15:0] npc_out;

  int          n_checks;
  int          n_fail;
  int          lat;
  logic [3:0]  wcnt;
  logic [31:0] pops[$];  // {Instr_dout, npc_out} accepted by decode
  logic [15:0] acks[$];  // imem_addr at each completed handshake

  fetch_unit #(
    .RESET_PC   (16'h3000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable_fetch  (enable_fetch),
    .br_taken      (br_taken),
    .taddr         (taddr),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .enable_decode (enable_decode),
    .Instr_dout    (Instr_dout),
    .npc_out       (npc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: ack after `lat` wait cycles of a held request.
  always_comb begin
    imem_ack   = imem_req && (int'(wcnt) == lat);
    imem_rdata = imem_ack ? ~imem_addr : 16'h0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    wcnt <= '0;
    else if (!imem_req || imem_ack) wcnt <= '0;
    else                           wcnt <= wcnt + 4'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Log this cycle's pop/handshake, then advance to just after the next edge.
  task automatic tick();
    #1;
    if (instr_valid && enable_decode && !br_taken) pops.push_back({Instr_dout, npc_out});
    if (imem_req && imem_ack) acks.push_back(imem_addr);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int latency, input logic dec_en);
    rst_n         = 1'b0;
    enable_fetch  = 1'b1;
    enable_decode = dec_en;
    br_taken      = 1'b0;
    taddr         = 16'h0000;
    lat           = latency;
    repeat (2) tick();
    pops.delete();
    acks.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!imem_req && n < 50) begin
      tick();
      n++;
    end
    check(tag, 32'(imem_req), 32'd1);
  endtask

  task automatic wait_pops(input string tag, input int need);
    int n = 0;
    while (pops.size() < need && n < 50) begin
      tick();
      n++;
    end
    check(tag, 32'(pops.size() >= need), 32'd1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // 1. Reset values, then one-wait-cycle memory with decode always ready.
    do_reset(1, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_req",   32'(imem_req),    32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", 32'(Instr_dout),  32'h5020);
    check("rst_npc",   32'(npc_out),     32'h0000);
    tick();
    rst_n = 1'b1;
    wait_req("t1_req");
    check("t1_addr", 32'(imem_addr), 32'h3000);
    repeat (12) tick();
    check("t1_npops", 32'(pops.size() >= 3), 32'd1);
    check("t1_pop0", pops[0], 32'hCFFF_3001);
    check("t1_pop1", pops[1], 32'hCFFE_3002);
    check("t1_pop2", pops[2], 32'hCFFD_3003);

    // 2. Zero-wait memory: one handshake per cycle.
    do_reset(0, 1'b1);
    wait_req("t2_req");
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t2_ack%0d", i),  32'(imem_ack),  32'd1);
      check($sformatf("t2_addr%0d", i), 32'(imem_addr), 32'h3000 + 32'(i));
      tick();
    end
    wait_pops("t2_npops", 2);
    check("t2_pop1", pops[1], 32'hCFFE_3002);

    // 3. Decode stalled: queue fills with two words, then fetch stops.
    do_reset(0, 1'b0);
    wait_req("t3_req");
    repeat (6) tick();
    check("t3_req_off", 32'(imem_req),    32'd0);
    check("t3_valid",   32'(instr_valid), 32'd1);
    check("t3_nacks",   32'(acks.size()), 32'd2);
    check("t3_head",    {Instr_dout, npc_out}, 32'hCFFF_3001);
    enable_decode = 1'b1;
    repeat (10) tick();
    check("t3_resume",  32'(acks.size() >= 3), 32'd1);
    check("t3_ack2",    32'(acks[2]), 32'h3002);
    check("t3_npops",   32'(pops.size() >= 4), 32'd1);
    check("t3_pop0",    pops[0], 32'hCFFF_3001);
    check("t3_pop1",    pops[1], 32'hCFFE_3002);
    check("t3_pop2",    pops[2], 32'hCFFD_3003);
    check("t3_pop3",    pops[3], 32'hCFFC_3004);

    // 4. Redirect to 4000 while the 3002 read waits 3 cycles for its ack.
    do_reset(3, 1'b1);
    begin
      int n = 0;
      while (!(imem_req && imem_addr == 16'h3002) && n < 50) begin
        tick();
        n++;
      end
    end
    check("t4_at3002", 32'(imem_addr), 32'h3002);
    br_taken = 1'b1;
    taddr    = 16'h4000;
    tick();
    br_taken = 1'b0;
    pops.delete();
    check("t4_flush", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t4_hold_req%0d", i),  32'(imem_req),  32'd1);
      check($sformatf("t4_hold_addr%0d", i), 32'(imem_addr), 32'h3002);
      tick();
    end
    check("t4_idle_req",   32'(imem_req),    32'd0);
    check("t4_idle_empty", 32'(instr_valid), 32'd0);
    wait_req("t4_req");
    check("t4_addr", 32'(imem_addr), 32'h4000);
    wait_pops("t4_npops", 1);
    check("t4_pop0", pops[0], 32'hBFFF_4001);

    // 5. Redirect to 5000 in the same cycle as the ack for 3001.
    do_reset(1, 1'b1);
    begin
      int n = 0;
      while (!(imem_req && imem_ack && imem_addr == 16'h3001) && n < 50) begin
        tick();
        n++;
      end
    end
    check("t5_ack3001", 32'(imem_ack && imem_addr == 16'h3001), 32'd1);
    br_taken = 1'b1;
    taddr    = 16'h5000;
    tick();
    br_taken = 1'b0;
    pops.delete();
    check("t5_flush", 32'(instr_valid), 32'd0);
    wait_req("t5_req");
    check("t5_addr", 32'(imem_addr), 32'h5000);
    wait_pops("t5_npops", 1);
    check("t5_pop0", pops[0], 32'hAFFF_5001);

    // 6. Asynchronous reset between clock edges with a word queued and a read open.
    do_reset(3, 1'b0);
    begin
      int n = 0;
      while (!(imem_req && instr_valid) && n < 50) begin
        tick();
        n++;
      end
    end
    check("t6_pre_req",   32'(imem_req),    32'd1);
    check("t6_pre_valid", 32'(instr_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_req",   32'(imem_req),    32'd0);
    check("t6_valid", 32'(instr_valid), 32'd0);
    check("t6_instr", 32'(Instr_dout),  32'h5020);
    tick();
    tick();
    rst_n = 1'b1;
    wait_req("t6_rereq");
    check("t6_addr", 32'(imem_addr), 32'h3000);

    // 7. PC wrap from FFFF to 0000.
    do_reset(0, 1'b1);
    wait_req("t7_req");
    br_taken = 1'b1;
    taddr    = 16'hFFFF;
    tick();
    br_taken = 1'b0;
    pops.delete();
    acks.delete();
    wait_req("t7_req2");
    check("t7_addr", 32'(imem_addr), 32'hFFFF);
    wait_pops("t7_npops", 2);
    check("t7_ack0", 32'(acks[0]), 32'hFFFF);
    check("t7_ack1", 32'(acks[1]), 32'h0000);
    check("t7_pop0", pops[0], 32'h0000_0000);
    check("t7_pop1", pops[1], 32'hFFFF_0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
